// File: rtl/io_port_bank.sv
// Peripheral responder for the CPU I/O port bus: LED register, synchronised switches,
// prescaled 16-bit timer and a TX FIFO drained over a valid/ready stream.
module io_port_bank #(
   parameter int FIFO_DEPTH  = 8,
   parameter int PRESCALE    = 100,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  dirport,
   input  logic [15:0] outport,
   input  logic        we,
   output logic [15:0] inport,
   input  logic [15:0] sw_in,
   output logic [15:0] led_out,
   output logic [15:0] tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0] PS_LAST   = PS_W'(PRESCALE - 1);
   localparam logic [4:0]      DEPTH_CNT = 5'(FIFO_DEPTH);

   typedef enum logic [4:0] {
      A_SW   = 5'h00,
      A_LED  = 5'h01,
      A_TCNT = 5'h02,
      A_TCTL = 5'h03,
      A_TXD  = 5'h04,
      A_TXST = 5'h05
   } port_addr_e;

   logic             we_q;
   logic             wr;
   logic             wr_led, wr_tcnt, wr_tctl, wr_fclr, push_req;

   logic [15:0]      sync_q [SYNC_STAGES];

   logic [PS_W-1:0]  prescale;
   logic [15:0]      tcount;
   logic             run, ovf;
   logic             tick, tick_eff;

   logic [15:0]      mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [4:0]       fifo_cnt;
   logic             fovf;
   logic             full, empty, pop, push_ok;

   // One write action per we high period: act only on the rising level.
   assign wr       = we & ~we_q;
   assign wr_led   = wr && (dirport == A_LED);
   assign wr_tcnt  = wr && (dirport == A_TCNT);
   assign wr_tctl  = wr && (dirport == A_TCTL);
   assign push_req = wr && (dirport == A_TXD);
   assign wr_fclr  = wr && (dirport == A_TXST);

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         we_q    <= 1'b0;
         led_out <= '0;
      end else begin
         we_q <= we;
         if (wr_led) led_out <= outport;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= sw_in;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   // A load or clear landing on a tick edge discards that tick, including its overflow.
   assign tick     = run && (prescale == PS_LAST);
   assign tick_eff = tick && !(wr_tcnt || (wr_tctl && outport[0]));

   always_ff @(posedge clk) begin
      if (rst) begin
         prescale <= '0;
         tcount   <= '0;
         run      <= 1'b0;
         ovf      <= 1'b0;
      end else begin
         if (run) prescale <= tick ? '0 : prescale + 1'b1;
         if (tick_eff) tcount <= tcount + 16'd1;
         if (wr_tctl && outport[2]) ovf <= 1'b0;
         if (tick_eff && (tcount == 16'hFFFF)) ovf <= 1'b1;
         if (wr_tcnt) tcount <= outport;
         if (wr_tctl) begin
            run <= outport[1];
            if (outport[0]) begin
               tcount   <= '0;
               prescale <= '0;
            end
         end
      end
   end

   assign full     = (fifo_cnt == DEPTH_CNT);
   assign empty    = (fifo_cnt == 5'd0);
   assign tx_valid = ~empty;
   assign pop      = tx_valid & tx_ready;
   // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
   assign push_ok  = push_req && (!full || pop);

   // NOTE: storage is not reset; tx_data is masked while empty so stale words never escape.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= outport;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
         fovf     <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         fifo_cnt <= fifo_cnt + 5'(push_ok) - 5'(pop);
         if (push_req && !push_ok) fovf <= 1'b1;
         else if (wr_fclr)         fovf <= 1'b0;
      end
   end

   assign tx_data = empty ? 16'h0000 : mem[rd_ptr];

   // NOTE: the default assignment first keeps this block free of latches.
   always_comb begin
      inport = 16'h0000;
      case (dirport)
         A_SW:    inport = sync_q[SYNC_STAGES-1];
         A_LED:   inport = led_out;
         A_TCNT:  inport = tcount;
         A_TCTL:  inport = {ovf, 13'b0, run, 1'b0};
         A_TXST:  inport = {7'b0, fovf, fifo_cnt, 1'b0, full, empty};
         default: inport = 16'h0000;
      endcase
   end

endmodule

// File: tb/tb_io_port_bank.sv
// Directed self-checking bench for io_port_bank (FIFO_DEPTH=8, PRESCALE=4, SYNC_STAGES=2).
module tb_io_port_bank;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  dirport;
   logic [15:0] outport;
   logic        we;
   logic [15:0] inport;
   logic [15:0] sw_in;
   logic [15:0] led_out;
   logic [15:0] tx_data;
   logic        tx_valid;
   logic        tx_ready;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   io_port_bank #(
      .FIFO_DEPTH (8),
      .PRESCALE   (4),
      .SYNC_STAGES(2)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .dirport (dirport),
      .outport (outport),
      .we      (we),
      .inport  (inport),
      .sw_in   (sw_in),
      .led_out (led_out),
      .tx_data (tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
      end
   endtask

   task automatic check_rd(input string tag, input logic [4:0] addr, input logic [15:0] exp);
      dirport = addr;
      #1;
      check(tag, inport, exp);
   endtask

   // Holds we for n_high edges (write lands on the first), then one idle edge with we low.
   task automatic write_port(input logic [4:0] addr, input logic [15:0] data, input int n_high);
      dirport = addr;
      outport = data;
      we      = 1'b1;
      repeat (n_high) @(posedge clk);
      #1 we = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "bench timed out");
   end

   initial begin
      rst      = 1'b1;
      we       = 1'b0;
      dirport  = 5'h00;
      outport  = 16'h0000;
      sw_in    = 16'h0000;
      tx_ready = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      check("rst_led_out", led_out, 16'h0000);
      check("rst_tx_valid", {15'b0, tx_valid}, 16'h0000);
      check("rst_tx_data", tx_data, 16'h0000);
      check_rd("rst_rd_led", 5'h01, 16'h0000);
      check_rd("rst_rd_tcnt", 5'h02, 16'h0000);
      check_rd("rst_rd_tctl", 5'h03, 16'h0000);
      check_rd("rst_rd_status", 5'h05, 16'h0001);
      idle(1);
      check_rd("rst_rd_sw", 5'h00, 16'h0000);
      check_rd("rst_rd_txd", 5'h04, 16'h0000);
      check_rd("rst_rd_undef", 5'h1F, 16'h0000);
      idle(1);

      // LED write: we high 3 cycles, data changed mid-pulse must not be taken
      dirport = 5'h01;
      outport = 16'hA5C3;
      we      = 1'b1;
      @(posedge clk);
      #1;
      check("led_first_edge", led_out, 16'hA5C3);
      outport = 16'hFFFF;
      repeat (2) @(posedge clk);
      #1 we = 1'b0;
      idle(1);
      check("led_one_shot", led_out, 16'hA5C3);
      check_rd("led_readback", 5'h01, 16'hA5C3);

      // Single push held 3 cycles -> count 1
      write_port(5'h04, 16'h1234, 3);
      check_rd("push_once_status", 5'h05, 16'h0008);
      check("push_once_valid", {15'b0, tx_valid}, 16'h0001);
      check("push_once_data", tx_data, 16'h1234);

      // Writes to read-only / undefined addresses are ignored
      write_port(5'h00, 16'hFFFF, 1);
      write_port(5'h1F, 16'hFFFF, 1);
      check("ignored_led", led_out, 16'hA5C3);
      check_rd("ignored_status", 5'h05, 16'h0008);
      check_rd("ignored_tcnt", 5'h02, 16'h0000);

      tx_ready = 1'b1;
      @(posedge clk);
      #1 tx_ready = 1'b0;
      check_rd("drain1_status", 5'h05, 16'h0001);
      check("drain1_valid", {15'b0, tx_valid}, 16'h0000);

      // Timer: clear+run, ticks every 4 edges after the write edge
      write_port(5'h03, 16'h0003, 1);
      idle(39);
      check_rd("timer_40clk", 5'h02, 16'h000A);
      write_port(5'h02, 16'hFFFF, 1);
      idle(3);
      check_rd("timer_wrap", 5'h02, 16'h0000);
      check_rd("timer_ovf", 5'h03, 16'h8002);
      write_port(5'h03, 16'h0006, 1);
      check_rd("timer_ovf_clr", 5'h03, 16'h0002);
      check_rd("timer_after_clr", 5'h02, 16'h0000);
      // Stop write lands on a tick edge: that tick still counts, then the count freezes
      write_port(5'h03, 16'h0000, 1);
      idle(10);
      check_rd("timer_frozen", 5'h02, 16'h0001);
      check_rd("timer_stopped", 5'h03, 16'h0000);

      // FIFO overflow: 9 pushes into 8 entries
      for (int i = 1; i <= 9; i++) write_port(5'h04, 16'(i), 1);
      check_rd("full_status", 5'h05, 16'h0142);
      check("full_head", tx_data, 16'h0001);
      tx_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         check($sformatf("drain_word%0d", i), tx_data, 16'(i));
         @(posedge clk);
         #1;
      end
      tx_ready = 1'b0;
      check("drained_valid", {15'b0, tx_valid}, 16'h0000);
      check("drained_data", tx_data, 16'h0000);
      check_rd("drained_status", 5'h05, 16'h0101);
      write_port(5'h05, 16'h0000, 1);
      check_rd("fovf_cleared", 5'h05, 16'h0001);

      // Full FIFO: pop and push on the same edge
      for (int i = 0; i < 8; i++) write_port(5'h04, 16'h0010 + 16'(i), 1);
      check_rd("refill_status", 5'h05, 16'h0042);
      dirport  = 5'h04;
      outport  = 16'h00AA;
      we       = 1'b1;
      tx_ready = 1'b1;
      @(posedge clk);
      #1;
      we       = 1'b0;
      tx_ready = 1'b0;
      check_rd("pushpop_status", 5'h05, 16'h0042);
      check("pushpop_head", tx_data, 16'h0011);
      idle(1);
      check("hold_while_stalled", tx_data, 16'h0011);
      tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("wrap_word%0d", i), tx_data, (i < 7) ? 16'h0011 + 16'(i) : 16'h00AA);
         @(posedge clk);
         #1;
      end
      tx_ready = 1'b0;
      check("wrap_empty", {15'b0, tx_valid}, 16'h0000);
      check_rd("wrap_status", 5'h05, 16'h0001);

      // Reset mid-drain
      write_port(5'h01, 16'h5555, 1);
      write_port(5'h04, 16'h00B1, 1);
      write_port(5'h04, 16'h00B2, 1);
      write_port(5'h04, 16'h00B3, 1);
      tx_ready = 1'b1;
      @(posedge clk);
      #1;
      check("middrain_head", tx_data, 16'h00B2);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      tx_ready = 1'b0;
      check("rst2_valid", {15'b0, tx_valid}, 16'h0000);
      check("rst2_data", tx_data, 16'h0000);
      check("rst2_led", led_out, 16'h0000);
      check_rd("rst2_status", 5'h05, 16'h0001);

      // Switch synchroniser: two edges of latency
      sw_in = 16'h5A5A;
      @(posedge clk);
      #1;
      check_rd("sw_after_1", 5'h00, 16'h0000);
      @(posedge clk);
      #1;
      check_rd("sw_after_2", 5'h00, 16'h5A5A);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
